adc_sar_sequencer: RTL and testbench

Successive-approximation controller for the 12-bit SAR ADC. It runs the track phase, then walks the binary search MSB to LSB. Each trial code is driven onto `dac_data`, which feeds `adc_row_col_decoder.data` directly. After a programmable settle time it strobes the comparator, keeps or drops the trial bit, and presents the final code with a one-cycle valid pulse.

---
 rtl/adc_sar_if.sv | 32 +++
 rtl/adc_sar_sequencer.sv | 154 +++++++++++++++
 tb/tb_adc_sar_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sar_if.sv
// rtl/adc_sar_if.sv - control/data bundle between a SAR sequencer and its driver
//
// Groups the conversion request, timing configuration, comparator decision
// and all sequencer outputs into one bundle.
//   master : start, sample_cycles, settle_cycles, comp_in driven;
//            sample, dac_data, comp_strobe, busy, result, result_valid observed
//   slave  : the sequencer side (directions mirrored)
interface adc_sar_if #(
  parameter int RESOLUTION = 12,
  parameter int CNT_W      = 4
);
  logic                  start;
  logic [CNT_W-1:0]      sample_cycles;
  logic [CNT_W-1:0]      settle_cycles;
  logic                  comp_in;
  logic                  sample;
  logic [RESOLUTION-1:0] dac_data;
  logic                  comp_strobe;
  logic                  busy;
  logic [RESOLUTION-1:0] result;
  logic                  result_valid;

  modport master (
    output start, sample_cycles, settle_cycles, comp_in,
    input  sample, dac_data, comp_strobe, busy, result, result_valid
  );

  modport slave (
    input  start, sample_cycles, settle_cycles, comp_in,
    output sample, dac_data, comp_strobe, busy, result, result_valid
  );
endinterface

// File: rtl/adc_sar_sequencer.sv
// rtl/adc_sar_sequencer.sv - successive-approximation conversion controller
//
// Runs the track phase, then a binary search MSB to LSB: each trial code is
// driven on dac_data, allowed to settle, the comparator is strobed and its
// decision keeps or drops the trial bit. The final code is published with a
// one-cycle result_valid pulse.
// Ports:
//   clk  : single clock
//   rst  : synchronous, active-high reset
//   bus  : adc_sar_if.slave
//          start, sample_cycles, settle_cycles, comp_in (in)
//          sample, dac_data, comp_strobe, busy, result, result_valid (out)
module adc_sar_sequencer #(
  parameter int RESOLUTION = 12,
  parameter int CNT_W      = 4
) (
  input  logic      clk,
  input  logic      rst,
  adc_sar_if.slave  bus
);

  localparam int IDX_W = $clog2(RESOLUTION);
  localparam logic [RESOLUTION-1:0] MSB_CODE = {1'b1, {(RESOLUTION-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    STROBE,
    DECIDE,
    DONE
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [CNT_W-1:0]      settle_lat, settle_lat_n;
  logic [IDX_W-1:0]      bit_idx, bit_idx_n;
  // The accumulator is the trial code itself, so dac_data is just this register.
  logic [RESOLUTION-1:0] acc, acc_n;
  logic [RESOLUTION-1:0] result_q, result_n;
  logic                  sample_q, sample_n;
  logic                  strobe_q, strobe_n;
  logic                  busy_q, busy_n;
  logic                  valid_q, valid_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      settle_lat <= '0;
      bit_idx    <= '0;
      acc        <= MSB_CODE;
      result_q   <= '0;
      sample_q   <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      settle_lat <= settle_lat_n;
      bit_idx    <= bit_idx_n;
      acc        <= acc_n;
      result_q   <= result_n;
      sample_q   <= sample_n;
      strobe_q   <= strobe_n;
      busy_q     <= busy_n;
      valid_q    <= valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    settle_lat_n = settle_lat;
    bit_idx_n    = bit_idx;
    acc_n        = acc;

    case (state)
      IDLE: begin
        acc_n = MSB_CODE;
        if (bus.start) begin
          settle_lat_n = bus.settle_cycles;
          // cnt counts down to zero, so a track length of S loads S-1; 0 behaves as 1.
          cnt_n     = (bus.sample_cycles == '0) ? '0 : bus.sample_cycles - CNT_W'(1);
          bit_idx_n = IDX_W'(RESOLUTION - 1);
          state_n   = SAMPLE;
        end
      end

      SAMPLE: begin
        if (cnt == '0) begin
          // The MSB trial is already on dac_data; a zero settle time goes straight to STROBE.
          state_n = (settle_lat == '0) ? STROBE : SETTLE;
          cnt_n   = (settle_lat == '0) ? '0 : settle_lat - CNT_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      SETTLE: begin
        if (cnt == '0) begin
          state_n = STROBE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      STROBE: begin
        state_n = DECIDE;
      end

      DECIDE: begin
        if (!bus.comp_in) begin
          acc_n[bit_idx] = 1'b0;
        end
        if (bit_idx == '0) begin
          state_n = DONE;
        end else begin
          bit_idx_n                   = bit_idx - IDX_W'(1);
          acc_n[bit_idx - IDX_W'(1)] = 1'b1;
          state_n = (settle_lat == '0) ? STROBE : SETTLE;
          cnt_n   = (settle_lat == '0) ? '0 : settle_lat - CNT_W'(1);
        end
      end

      DONE: begin
        // Preload the idle code so dac_data is back at mid-scale in the first IDLE cycle.
        acc_n   = MSB_CODE;
        state_n = IDLE;
      end

      default: begin
        acc_n   = MSB_CODE;
        state_n = IDLE;
      end
    endcase

    // All outputs are registered versions of what the next state implies.
    sample_n = (state_n == SAMPLE);
    strobe_n = (state_n == STROBE);
    busy_n   = (state_n != IDLE);
    valid_n  = (state_n == DONE);
    result_n = valid_n ? acc_n : result_q;
  end

  assign bus.sample       = sample_q;
  assign bus.dac_data     = acc;
  assign bus.comp_strobe  = strobe_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// tb/tb_adc_sar_sequencer.sv - self-checking bench for adc_sar_sequencer
module tb_adc_sar_sequencer;

  localparam int RES = 12;

  logic clk;
  logic rst;
  logic [RES-1:0] vin;
  logic comp_q;
  logic in_dec;
  logic noise;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int dac_bad = 0;
  logic [RES-1:0] trials[$];

  typedef struct {
    logic [RES-1:0] vin;
    int             s;
    int             t;
    bit             chg;
    logic [RES-1:0] exp_res;
    int             exp_cyc;
  } vec_t;

  vec_t vecs[7];

  adc_sar_if #(.RESOLUTION(RES), .CNT_W(4)) bus ();

  adc_sar_sequencer #(.RESOLUTION(RES), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal comparator: latch vin >= dac on the strobe cycle, present it in the next
  // cycle; outside that cycle comp_in carries random noise.
  always @(posedge clk) begin
    if (bus.comp_strobe) begin
      comp_q <= (vin >= bus.dac_data);
      in_dec <= 1'b1;
    end else begin
      in_dec <= 1'b0;
      noise  <= 1'($urandom);
    end
  end
  assign bus.comp_in = in_dec ? comp_q : noise;

  always @(negedge clk) begin
    if (bus.result_valid) valid_cnt++;
    if (!rst && $isunknown(bus.dac_data)) dac_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(int s, int t);
    return ((s == 0) ? 1 : s) + RES * (t + 2) + 1;
  endfunction

  // Trial for bit k: ideal upper bits of vin above k, plus bit k set.
  function automatic logic [RES-1:0] exp_trial(logic [RES-1:0] v, int k);
    int vi;
    int hi;
    vi = int'(v);
    hi = (vi >> (k + 1)) << (k + 1);
    return RES'(hi | (1 << k));
  endfunction

  task automatic run_conv(input logic [RES-1:0] v, input int s, input int t,
                          input bit chg, input bit poke,
                          output logic [RES-1:0] res, output int vcyc,
                          output int scnt, output int strobes);
    int g;
    int cyc;
    g = 0;
    while (bus.busy && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (bus.busy) check("idle_wait_timeout", 32'd1, 32'd0);
    vin = v;
    bus.sample_cycles = 4'(s);
    bus.settle_cycles = 4'(t);
    bus.start = 1'b1;
    trials.delete();
    cyc = 0;
    vcyc = -1;
    scnt = 0;
    strobes = 0;
    res = 'x;
    while (vcyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
      if (chg && cyc == 3) begin
        bus.sample_cycles = 4'($urandom);
        bus.settle_cycles = 4'($urandom);
      end
      if (bus.sample) scnt++;
      if (bus.comp_strobe) begin
        strobes++;
        trials.push_back(bus.dac_data);
      end
      if (bus.result_valid) begin
        vcyc = cyc;
        res = bus.result;
      end
    end
    if (poke) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("start_in_done_ignored", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic conv_check(input string name, input logic [RES-1:0] v, input int s,
                            input int t, input bit chg, input bit poke,
                            input logic [RES-1:0] exp_res, input int exp_cyc);
    logic [RES-1:0] res;
    int vcyc;
    int scnt;
    int strobes;
    int mism;
    run_conv(v, s, t, chg, poke, res, vcyc, scnt, strobes);
    check({name, "_result"}, 32'(res), 32'(exp_res));
    check({name, "_latency"}, vcyc, exp_cyc);
    check({name, "_sample_len"}, scnt, (s == 0) ? 1 : s);
    check({name, "_strobes"}, strobes, RES);
    mism = 0;
    for (int i = 0; i < trials.size(); i++) begin
      if (trials[i] !== exp_trial(v, RES - 1 - i)) mism++;
    end
    check({name, "_trials"}, mism, 0);
  endtask

  initial begin
    int cyc;
    int v1;
    int v2;
    int vstart;
    logic b27;
    logic b28;
    logic s28;
    logic [RES-1:0] rv;
    int rs;
    int rt;

    vecs[0] = '{vin: 12'hA5C, s: 2,  t: 0,  chg: 1'b0, exp_res: 12'hA5C, exp_cyc: 27};
    vecs[1] = '{vin: 12'h000, s: 1,  t: 3,  chg: 1'b0, exp_res: 12'h000, exp_cyc: 62};
    vecs[2] = '{vin: 12'hFFF, s: 1,  t: 3,  chg: 1'b0, exp_res: 12'hFFF, exp_cyc: 62};
    vecs[3] = '{vin: 12'h5A5, s: 0,  t: 1,  chg: 1'b0, exp_res: 12'h5A5, exp_cyc: 38};
    vecs[4] = '{vin: 12'h5A5, s: 0,  t: 1,  chg: 1'b1, exp_res: 12'h5A5, exp_cyc: 38};
    vecs[5] = '{vin: 12'h001, s: 15, t: 15, chg: 1'b0, exp_res: 12'h001, exp_cyc: 220};
    vecs[6] = '{vin: 12'h7FF, s: 4,  t: 2,  chg: 1'b0, exp_res: 12'h7FF, exp_cyc: 53};

    rst = 1'b1;
    vin = '0;
    bus.start = 1'b0;
    bus.sample_cycles = '0;
    bus.settle_cycles = '0;
    repeat (3) @(negedge clk);
    check("reset_dac", 32'(bus.dac_data), 32'h800);
    check("reset_result", 32'(bus.result), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_sample", 32'(bus.sample), 32'd0);
    check("reset_strobe", 32'(bus.comp_strobe), 32'd0);
    check("reset_valid", 32'(bus.result_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      conv_check($sformatf("vec%0d", i), vecs[i].vin, vecs[i].s, vecs[i].t,
                 vecs[i].chg, 1'b0, vecs[i].exp_res, vecs[i].exp_cyc);
      if (i == 0) begin
        check("basic_trial0", 32'(trials[0]), 32'h800);
        check("basic_trial1", 32'(trials[1]), 32'hC00);
        check("basic_trial2", 32'(trials[2]), 32'hA00);
        check("basic_trial3", 32'(trials[3]), 32'hB00);
      end
    end

    conv_check("done_poke", 12'h6E1, 2, 1, 1'b0, 1'b1, 12'h6E1, exp_latency(2, 1));

    // start held high across a whole conversion and into the next one
    while (bus.busy) @(negedge clk);
    vin = 12'h3C7;
    bus.sample_cycles = 4'd1;
    bus.settle_cycles = 4'd0;
    bus.start = 1'b1;
    vstart = valid_cnt;
    cyc = 0;
    v1 = -1;
    v2 = -1;
    b27 = 1'bx;
    b28 = 1'bx;
    s28 = 1'bx;
    while (cyc < 70) begin
      @(negedge clk);
      cyc++;
      if (bus.result_valid) begin
        if (v1 < 0) v1 = cyc;
        else if (v2 < 0) v2 = cyc;
      end
      if (cyc == 27) b27 = bus.busy;
      if (cyc == 28) begin
        b28 = bus.busy;
        s28 = bus.sample;
      end
      if (cyc == 30) bus.start = 1'b0;
    end
    check("held_first_valid", v1, 26);
    check("held_idle_gap", 32'(b27), 32'd0);
    check("held_reaccept_busy", 32'(b28), 32'd1);
    check("held_reaccept_sample", 32'(s28), 32'd1);
    check("held_second_valid", v2, 53);
    check("held_valid_count", valid_cnt - vstart, 2);
    check("held_result", 32'(bus.result), 32'h3C7);

    // reset during bit 5, with start also high
    vin = 12'h9B4;
    bus.sample_cycles = 4'd1;
    bus.settle_cycles = 4'd0;
    bus.start = 1'b1;
    vstart = valid_cnt;
    cyc = 0;
    while (cyc < 14) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
    end
    check("rst_bit5_strobe", 32'(bus.comp_strobe), 32'd1);
    check("rst_bit5_trial", 32'(bus.dac_data), 32'(exp_trial(12'h9B4, 5)));
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check("rst_mid_dac", 32'(bus.dac_data), 32'h800);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_result", 32'(bus.result), 32'h0);
    check("rst_mid_sample", 32'(bus.sample), 32'd0);
    check("rst_mid_valid", 32'(bus.result_valid), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_no_valid", valid_cnt - vstart, 0);
    conv_check("after_rst", 12'h123, 1, 0, 1'b0, 1'b0, 12'h123, 26);

    // randomized conversions against the reference model
    for (int i = 0; i < 20; i++) begin
      rv = RES'($urandom);
      rs = $urandom_range(0, 15);
      rt = $urandom_range(0, 15);
      conv_check($sformatf("rand%0d", i), rv, rs, rt, 1'($urandom_range(0, 1)), 1'b0,
                 rv, exp_latency(rs, rt));
    end

    // sweep across the code range, including both end points
    for (int v = 0; v < 4096; v += 3) begin
      conv_check($sformatf("sweep%0d", v), RES'(v), 1, 0, 1'b0, 1'b0, RES'(v), 26);
    end

    check("dac_data_legal", dac_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
